bram_lat: RTL and testbench
===========================

Name: bram_lat

Overview:
- Parametrised successor to the team's single-port block RAM.
- Adds configurable data and address width, per-byte write strobes, and a valid/ready request handshake.
- Read latency is modelled exactly by a configurable delay line.
- Optional post-reset memory clear.
- Sits between the user-project memory arbiter and the on-chip BRAM, so firmware/DMA timing studies can sweep latency without changing the arbiter.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8
ADDR_W, 13, word-address width; depth = 2**ADDR_W words
LATENCY, 10, cycles from request accept edge to response; legal range 1..32
CLEAR_ON_RESET, 1, 1 = zero all words after reset before accepting requests; 0 = skip the clear

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = write, 0 = read
req_wstrb  in  DATA_W/8  byte write enables; ignored on reads
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  read data valid; single-cycle pulse per read
rsp_rdata  out  DATA_W  read data; forced to 0 when rsp_valid=0
rd_pending  out  6  reads accepted but not yet responded (0..LATENCY)
init_done  out  1  high once the clear sweep is finished (or immediately when CLEAR_ON_RESET=0)

Behaviour:
- Reset (asynchronous, RST=1) drives:
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rd_pending=0, init_done=0.
  - All delay-line valid bits cleared, clear counter=0, state=INIT.
  - RAM contents are not reset directly.
- State INIT, CLEAR_ON_RESET=1:
  - Each cycle writes 0 to RAM[cnt], then cnt++.
  - After writing word 2**ADDR_W-1, next state is RUN.
  - The sweep takes exactly 2**ADDR_W cycles after RST deasserts.
  - req_ready=0 throughout; requests are not accepted and are not lost (the requester holds them).
- State INIT, CLEAR_ON_RESET=0: transitions to RUN on the first edge after RST deasserts.
- State RUN:
  - init_done=1 and req_ready=1 every cycle; no back-pressure in RUN.
  - Accept is req_valid & req_ready, evaluated at the rising edge.
- Write accept:
  - For each byte lane i with req_wstrb[i]=1, RAM[req_addr] byte i <= req_wdata byte i.
  - Other lanes are unchanged.
  - No response is generated; rd_pending is unaffected.
  - wstrb=0 is a legal no-op.
- Read accept:
  - RAM[req_addr] is sampled at the accept edge and enters a LATENCY-deep delay line of {valid, data}.
  - With accept at edge k, rsp_valid=1 and rsp_rdata=data during the single cycle following edge k+LATENCY-1.
  - LATENCY=1 therefore equals the classic one-cycle BRAM read.
- Ordering:
  - Back-to-back accepts are allowed every cycle.
  - Responses come out in order, one per cycle, with gaps that mirror the request gaps exactly.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data.
- rd_pending:
  - +1 on a read accept, -1 on a cycle where rsp_valid=1.
  - Both in the same cycle leaves it unchanged.
  - Never exceeds LATENCY.
- Address wrap: none needed; req_addr covers the full depth.
- Reset mid-operation:
  - In-flight reads are discarded and no rsp_valid follows.
  - Partially written state is irrelevant because INIT re-clears memory (when CLEAR_ON_RESET=1).
  - With CLEAR_ON_RESET=0, memory contents survive reset.

Test Plan:
- Reset with CLEAR_ON_RESET=1, ADDR_W=4 -> req_ready stays 0 for 16 cycles after RST falls, then init_done=1; reads of addr 0..15 all return 0x00000000.
- LATENCY=10: write 0xDEADBEEF to addr 5 at edge k, read addr 5 at edge k+1 -> rsp_valid high only in the cycle after edge k+10, rsp_rdata=0xDEADBEEF; rsp_rdata=0 in all other cycles.
- Byte strobes: write 0x11223344 to addr 3, then wstrb=4'b0101 with data 0xAABBCCDD -> read returns 0x11BB33DD.
- Pipelining, LATENCY=3: reads of addr 1,2,3 on consecutive edges (holding 0xA,0xB,0xC) -> three consecutive rsp_valid cycles returning 0xA,0xB,0xC; rd_pending goes 1,2,3,2,1,0.
- Reset mid-flight: 4 reads accepted with LATENCY=10, RST pulsed 2 cycles later -> no rsp_valid at all; rd_pending=0 immediately on RST.
- LATENCY=1, CLEAR_ON_RESET=0: req_ready=1 in the first cycle after RST falls; a read accepted at edge k responds in the cycle after edge k; the memory value written before reset is still readable.

Source files
------------

// File: rtl/bram_lat.sv
// bram_lat: single-port block RAM with byte strobes, a valid/ready request
// port, an exact configurable read-latency delay line and optional clear.
module bram_lat #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 13,
    parameter int LATENCY        = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [5:0]            rd_pending,
    output logic                  init_done
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int DLW   = LATENCY * DATA_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t                            state;
    logic [ADDR_W-1:0]                 cnt;
    logic [DATA_W-1:0]                 mem [DEPTH];
    logic [LATENCY-1:0]                dl_v;
    logic [LATENCY-1:0][DATA_W-1:0]    dl_d;
    logic [DATA_W-1:0]                 wmask;
    logic [DATA_W-1:0]                 rd_word;
    logic                              acc_wr;
    logic                              acc_rd;
    logic                              clr_we;

    assign acc_wr = req_valid & req_ready & req_we;
    assign acc_rd = req_valid & req_ready & ~req_we;
    assign clr_we = CLEAR_ON_RESET && (state == INIT);

    always_comb begin
        wmask = '0;
        for (int i = 0; i < NB; i++)
            wmask[i*8 +: 8] = {8{req_wstrb[i]}};
    end

    // Idle delay-line slots carry zero so the output needs no masking.
    assign rd_word = acc_rd ? mem[req_addr] : '0;

    always_ff @(posedge CLK) begin
        if (clr_we)
            mem[cnt] <= '0;
        else if (acc_wr)
            mem[req_addr] <= (mem[req_addr] & ~wmask)
                           | (req_wdata & wmask);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= INIT;
            cnt        <= '0;
            req_ready  <= 1'b0;
            init_done  <= 1'b0;
            rd_pending <= '0;
            dl_v       <= '0;
            dl_d       <= '0;
        end else begin
            unique case (state)
                INIT: begin
                    if (!CLEAR_ON_RESET || (&cnt)) begin
                        state     <= RUN;
                        req_ready <= 1'b1;
                        init_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    req_ready <= 1'b1;
                    init_done <= 1'b1;
                end
            endcase
            dl_v       <= (dl_v << 1) | LATENCY'(acc_rd);
            dl_d       <= (dl_d << DATA_W) | DLW'(rd_word);
            rd_pending <= rd_pending + 6'(acc_rd) - 6'(rsp_valid);
        end
    end

    assign rsp_valid = dl_v[LATENCY-1];
    assign rsp_rdata = dl_d[LATENCY-1];

endmodule

// File: tb/tb_bram_lat.sv
// Bench for bram_lat: three configurations driven in parallel, checked
// against a due-cycle scoreboard plus hand-computed literal expectations.
module tb_bram_lat;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [3:0]  req_wstrb = '0;
    logic [3:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;

    logic        rdy [3];
    logic        rv [3];
    logic [31:0] rd [3];
    logic [5:0]  pend [3];
    logic        idn [3];

    int n_cmp = 0;
    int n_bad = 0;

    int LAT [3] = '{10, 3, 1};
    bit CLR [3] = '{1'b1, 1'b1, 1'b0};

    logic [31:0] mm [3][16];
    bit          kn [3][16];
    bit          sv [3][64];
    logic [31:0] sd [3][64];
    bit          sk [3][64];
    int          outs [3];
    int          since [3];
    bit          rdym [3];
    int          cyc = 0;

    always #5 clk = ~clk;

    bram_lat #(.DATA_W(32), .ADDR_W(4), .LATENCY(10), .CLEAR_ON_RESET(1'b1)) u_a (
        .CLK(clk), .RST(rst), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_we(req_we), .req_wstrb(req_wstrb), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rv[0]), .rsp_rdata(rd[0]),
        .rd_pending(pend[0]), .init_done(idn[0]));

    bram_lat #(.DATA_W(32), .ADDR_W(4), .LATENCY(3), .CLEAR_ON_RESET(1'b1)) u_b (
        .CLK(clk), .RST(rst), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_we(req_we), .req_wstrb(req_wstrb), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rv[1]), .rsp_rdata(rd[1]),
        .rd_pending(pend[1]), .init_done(idn[1]));

    bram_lat #(.DATA_W(32), .ADDR_W(4), .LATENCY(1), .CLEAR_ON_RESET(1'b0)) u_c (
        .CLK(clk), .RST(rst), .req_valid(req_valid), .req_ready(rdy[2]),
        .req_we(req_we), .req_wstrb(req_wstrb), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rv[2]), .rsp_rdata(rd[2]),
        .rd_pending(pend[2]), .init_done(idn[2]));

    task automatic check(input string nm, input int i,
                         input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] t=%0t: got %h want %h", nm, i, $time, got, exp);
        end
    endtask

    // Reference model: a read accepted at edge k is due in cycle k+LAT-1.
    task automatic model_step();
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                outs[i]  = 0;
                since[i] = 0;
                rdym[i]  = 1'b0;
                for (int s = 0; s < 64; s++) sv[i][s] = 1'b0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 3; i++) begin
                int s;
                if (req_valid && rdym[i]) begin
                    if (req_we) begin
                        for (int b = 0; b < 4; b++)
                            if (req_wstrb[b])
                                mm[i][req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
                        if (req_wstrb == 4'hf) kn[i][req_addr] = 1'b1;
                    end else begin
                        s = (cyc + LAT[i] - 1) % 64;
                        sv[i][s] = 1'b1;
                        sd[i][s] = mm[i][req_addr];
                        sk[i][s] = kn[i][req_addr];
                        outs[i]++;
                    end
                end
                since[i]++;
                if (CLR[i] && since[i] == 16)
                    for (int j = 0; j < 16; j++) begin
                        mm[i][j] = '0;
                        kn[i][j] = 1'b1;
                    end
                rdym[i] = since[i] >= (CLR[i] ? 16 : 1);
            end
        end
    endtask

    task automatic compare_step();
        for (int i = 0; i < 3; i++) begin
            int s;
            bit ev;
            s  = cyc % 64;
            ev = sv[i][s];
            check("req_ready", i, 32'(rdy[i]), 32'(rdym[i]));
            check("init_done", i, 32'(idn[i]), 32'(rdym[i]));
            check("rsp_valid", i, 32'(rv[i]), 32'(ev));
            check("rd_pending", i, 32'(pend[i]), outs[i]);
            if (!ev)
                check("rdata_idle", i, rd[i], 32'h0);
            else if (sk[i][s])
                check("rdata", i, rd[i], sd[i][s]);
            if (ev) begin
                sv[i][s] = 1'b0;
                outs[i]--;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        compare_step();
    end

    task automatic req(input logic we, input logic [3:0] st,
                       input logic [3:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_we    = we;
        req_wstrb = st;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_wstrb = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Counts cycles after an accept edge until the response shows up.
    task automatic chk_rsp(input int i, input int lat,
                           input logic [31:0] v, input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rv[i] && n < 40);
        check({nm, "_lat"}, i, n, lat);
        check({nm, "_data"}, i, rd[i], v);
    endtask

    initial begin
        int hits;
        int exp_p [6];
        exp_p = '{1, 2, 3, 2, 1, 0};

        idle(3);
        check("rst_pending", 0, 32'(pend[0]), 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("noclr_ready_first", 2, 32'(rdy[2]), 1);
        check("clr_ready_first", 0, 32'(rdy[0]), 0);
        repeat (14) @(posedge clk);
        @(negedge clk);
        check("clr_ready_15", 0, 32'(rdy[0]), 0);
        @(posedge clk);
        @(negedge clk);
        check("clr_ready_16", 0, 32'(rdy[0]), 1);
        check("clr_done_16", 1, 32'(idn[1]), 1);

        for (int a = 0; a < 16; a++) req(1'b0, 4'h0, 4'(a), 32'h0);
        idle(12);

        req(1'b1, 4'hf, 4'd5, 32'hDEADBEEF);
        req(1'b0, 4'h0, 4'd5, 32'h0);
        chk_rsp(0, 10, 32'hDEADBEEF, "raw_lat10");
        idle(2);

        req(1'b1, 4'hf, 4'd3, 32'h11223344);
        req(1'b1, 4'b0101, 4'd3, 32'hAABBCCDD);
        req(1'b0, 4'h0, 4'd3, 32'h0);
        chk_rsp(1, 3, 32'h11BB33DD, "strobe");
        idle(12);

        req(1'b1, 4'hf, 4'd1, 32'hA);
        req(1'b1, 4'hf, 4'd2, 32'hB);
        req(1'b1, 4'hf, 4'd3, 32'hC);
        for (int j = 0; j < 6; j++) begin
            req_valid = (j < 3);
            req_we    = 1'b0;
            req_addr  = 4'(j + 1);
            @(posedge clk);
            @(negedge clk);
            check("pipe_pending", 1, 32'(pend[1]), exp_p[j]);
            if (j >= 2 && j <= 4)
                check("pipe_data", 1, rd[1], 32'(j + 8));
        end
        req_valid = 1'b0;
        idle(12);

        for (int a = 1; a <= 4; a++) req(1'b0, 4'h0, 4'(a), 32'h0);
        idle(2);
        check("flight_pending", 0, 32'(pend[0]), 4);
        rst = 1'b1;
        #1;
        check("rst_mid_pending", 0, 32'(pend[0]), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        hits = 0;
        repeat (30) begin
            @(negedge clk);
            if (rv[0]) hits++;
        end
        check("no_rsp_after_rst", 0, hits, 0);

        req(1'b0, 4'h0, 4'd5, 32'h0);
        fork
            chk_rsp(2, 1, 32'hDEADBEEF, "keep_noclr");
            chk_rsp(0, 10, 32'h0, "cleared");
        join
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
